// File: rtl/float_mult_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one pipelined float multiplier.
// Issued requester IDs queue in an in-order tag FIFO so each result is steered back to its owner.
module float_mult_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TAG_W        = $clog2(NUM_REQ),
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                               clk,
    input  logic                               sclr,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*32-1:0]              req_a,
    input  logic [NUM_REQ*32-1:0]              req_b,
    output logic [NUM_REQ-1:0]                 req_grant,
    output logic                               mult_sclr,
    output logic                               mult_nd,
    output logic [31:0]                        mult_a,
    output logic [31:0]                        mult_b,
    input  logic                               mult_rdy,
    input  logic [31:0]                        mult_result,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [31:0]                        resp_result,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
    output logic                               err_orphan
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int AW    = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [CNT_W-1:0] count;

    logic [31:0]      a_arr [NUM_REQ];
    logic [31:0]      b_arr [NUM_REQ];

    logic             fifo_full;
    logic             pop;
    logic             grant_found;
    logic [TAG_W-1:0] grant_id;
    logic [TAG_W:0]   sum;
    logic [TAG_W-1:0] cand;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[32*i +: 32];
        assign b_arr[i] = req_b[32*i +: 32];
    end

    assign mult_sclr = sclr;
    assign inflight  = count;
    assign fifo_full = (count == CNT_W'(MAX_INFLIGHT));
    assign pop       = mult_rdy && (count != '0);

    // A result leaving in the same cycle frees a slot, so a full FIFO can still accept a grant.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        cand        = '0;
        if (!sclr && (!fifo_full || pop)) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, ptr} + (TAG_W+1)'(k);
                if (sum >= (TAG_W+1)'(NUM_REQ)) begin
                    sum = sum - (TAG_W+1)'(NUM_REQ);
                end
                cand = sum[TAG_W-1:0];
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_id    = cand;
                end
            end
        end
    end

    assign req_grant = grant_found ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (grant_found) begin
            tag_mem[wr_idx] <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            ptr         <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            count       <= '0;
            mult_nd     <= 1'b0;
            mult_a      <= '0;
            mult_b      <= '0;
            resp_valid  <= '0;
            resp_result <= '0;
            err_orphan  <= 1'b0;
        end else begin
            mult_nd    <= grant_found;
            resp_valid <= '0;

            if (grant_found) begin
                mult_a <= a_arr[grant_id];
                mult_b <= b_arr[grant_id];
                ptr    <= (grant_id == TAG_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                wr_idx <= (wr_idx == AW'(MAX_INFLIGHT-1)) ? '0 : wr_idx + 1'b1;
            end

            // A result with no outstanding tag cannot be routed; flag it and drop it.
            if (pop) begin
                resp_valid  <= NUM_REQ'(1) << tag_mem[rd_idx];
                resp_result <= mult_result;
                rd_idx      <= (rd_idx == AW'(MAX_INFLIGHT-1)) ? '0 : rd_idx + 1'b1;
            end else if (mult_rdy) begin
                err_orphan <= 1'b1;
            end

            case ({grant_found, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
